// File: rtl/phy_rx_lane_sched.sv
// Four-lane RX scheduler: per-lane comma alignment, per-lane FIFOs and a
// round-robin arbiter feeding a single-register output stage.
module phy_rx_lane_sched #(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] COMMA     = 8'hBC,
   parameter int         ALIGN_CNT = 4
) (
   input  logic       clk4f,
   input  logic       reset,
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic [3:0] valid_in,
   output logic [7:0] out_data,
   output logic [1:0] out_lane,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] active,
   output logic [3:0] fifo_full,
   output logic [3:0] overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int KW = $clog2(ALIGN_CNT + 1);

   typedef enum logic {INACTIVE = 1'b0, ACTIVE = 1'b1} lane_state_t;

   logic [7:0] lane_in       [4];
   logic [7:0] head          [4];
   logic       lane_active   [4];
   logic       lane_full     [4];
   logic       lane_ovf      [4];
   logic       lane_nonempty [4];

   logic [3:0] nonempty;
   logic [3:0] pop;
   logic       load;
   logic [1:0] grant;
   logic       grant_valid;

   logic [7:0] out_data_reg;
   logic [1:0] out_lane_reg;
   logic       out_valid_reg;
   logic [1:0] last_grant_reg;

   assign lane_in[0] = in0;
   assign lane_in[1] = in1;
   assign lane_in[2] = in2;
   assign lane_in[3] = in3;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         lane_state_t   state_reg, state_next;
         logic [KW-1:0] ccnt_reg, ccnt_next;
         logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
         logic [CW-1:0] count_reg, count_next;
         logic          full_reg, ovf_reg;
         logic          is_comma, push_req, push, drop;
         logic [7:0]    mem [DEPTH];

         assign is_comma = (lane_in[gi] == COMMA);

         always_comb begin
            state_next = state_reg;
            ccnt_next  = ccnt_reg;
            push_req   = 1'b0;
            case (state_reg)
               INACTIVE: begin
                  if (valid_in[gi]) begin
                     if (is_comma) begin
                        ccnt_next = ccnt_reg + KW'(1);
                        if (ccnt_reg == KW'(ALIGN_CNT - 1))
                           state_next = ACTIVE;
                     end else begin
                        ccnt_next = '0;
                     end
                  end
               end
               ACTIVE:  push_req = valid_in[gi] && !is_comma;
               default: state_next = INACTIVE;
            endcase
         end

         // A full FIFO still accepts a byte when its head leaves in the same cycle.
         assign push       = push_req && ((count_reg != CW'(DEPTH)) || pop[gi]);
         assign drop       = push_req && !push;
         assign count_next = count_reg + CW'(push) - CW'(pop[gi]);

         always_ff @(posedge clk4f or negedge reset) begin
            if (!reset) begin
               state_reg  <= INACTIVE;
               ccnt_reg   <= '0;
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
               full_reg   <= 1'b0;
               ovf_reg    <= 1'b0;
            end else begin
               state_reg <= state_next;
               ccnt_reg  <= ccnt_next;
               count_reg <= count_next;
               full_reg  <= (count_next == CW'(DEPTH));
               ovf_reg   <= ovf_reg | drop;
               if (push)
                  wr_ptr_reg <= wr_ptr_reg + AW'(1);
               if (pop[gi])
                  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
         end

         always_ff @(posedge clk4f) begin
            if (push)
               mem[wr_ptr_reg] <= lane_in[gi];
         end

         assign head[gi]          = mem[rd_ptr_reg];
         assign lane_nonempty[gi] = (count_reg != '0);
         assign lane_active[gi]   = (state_reg == ACTIVE);
         assign lane_full[gi]     = full_reg;
         assign lane_ovf[gi]      = ovf_reg;
      end
   endgenerate

   always_comb begin
      nonempty  = '0;
      active    = '0;
      fifo_full = '0;
      overflow  = '0;
      for (int i = 0; i < 4; i++) begin
         nonempty[i]  = lane_nonempty[i];
         active[i]    = lane_active[i];
         fifo_full[i] = lane_full[i];
         overflow[i]  = lane_ovf[i];
      end
   end

   // Scan lanes starting just after the last winner; first non-empty one wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!grant_valid && nonempty[last_grant_reg + 2'(k)]) begin
            grant       = last_grant_reg + 2'(k);
            grant_valid = 1'b1;
         end
      end
   end

   assign load = !out_valid_reg || out_ready;
   assign pop  = (load && grant_valid) ? (4'b0001 << grant) : 4'b0000;

   always_ff @(posedge clk4f or negedge reset) begin
      if (!reset) begin
         out_data_reg   <= '0;
         out_lane_reg   <= '0;
         out_valid_reg  <= 1'b0;
         last_grant_reg <= 2'd3;
      end else if (load) begin
         out_valid_reg <= grant_valid;
         if (grant_valid) begin
            out_data_reg   <= head[grant];
            out_lane_reg   <= grant;
            last_grant_reg <= grant;
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_lane  = out_lane_reg;
   assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_phy_rx_lane_sched.sv
// Bench for phy_rx_lane_sched: queue-based lane model compared every cycle,
// directed alignment/arbitration/backpressure/reset cases, then random traffic.
module tb_phy_rx_lane_sched;
   localparam int         DEPTH     = 4;
   localparam logic [7:0] COMMA     = 8'hBC;
   localparam int         ALIGN_CNT = 4;

   logic       clk4f = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
   logic [3:0] valid_in = '0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [1:0] out_lane;
   logic       out_valid;
   logic [3:0] active, fifo_full, overflow;

   phy_rx_lane_sched #(.DEPTH(DEPTH), .COMMA(COMMA), .ALIGN_CNT(ALIGN_CNT)) dut (
      .clk4f(clk4f), .reset(reset),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .valid_in(valid_in),
      .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
      .out_ready(out_ready),
      .active(active), .fifo_full(fifo_full), .overflow(overflow)
   );

   always #5 clk4f = ~clk4f;

   // Reference model: byte queues per lane plus comma counts and flags.
   logic [7:0] q [4][$];
   int         ccnt [4];
   bit         m_act [4];
   bit         m_ovf [4];
   bit         m_valid;
   logic [7:0] m_data;
   logic [1:0] m_lane;
   int         m_last;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] align_seq [8] = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         ccnt[i]  = 0;
         m_act[i] = 0;
         m_ovf[i] = 0;
      end
      m_valid = 0;
      m_data  = '0;
      m_lane  = '0;
      m_last  = 3;
   endtask

   task automatic model_step();
      logic [7:0] b [4];
      int pre [4];
      int pl;
      int l;
      b[0] = in0; b[1] = in1; b[2] = in2; b[3] = in3;
      pl = -1;
      for (int i = 0; i < 4; i++) pre[i] = q[i].size();
      if (!m_valid || out_ready) begin
         for (int k = 1; k <= 4; k++) begin
            l = (m_last + k) % 4;
            if (pl < 0 && pre[l] > 0) pl = l;
         end
         if (pl >= 0) begin
            m_data  = q[pl].pop_front();
            m_lane  = 2'(pl);
            m_valid = 1;
            m_last  = pl;
         end else begin
            m_valid = 0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (valid_in[i]) begin
            if (!m_act[i]) begin
               if (b[i] == COMMA) begin
                  ccnt[i]++;
                  if (ccnt[i] == ALIGN_CNT) m_act[i] = 1;
               end else begin
                  ccnt[i] = 0;
               end
            end else if (b[i] != COMMA) begin
               if (pre[i] == DEPTH && pl != i) m_ovf[i] = 1;
               else q[i].push_back(b[i]);
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] e_act, e_full, e_ovf;
      for (int i = 0; i < 4; i++) begin
         e_act[i]  = m_act[i];
         e_full[i] = (q[i].size() == DEPTH);
         e_ovf[i]  = m_ovf[i];
      end
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("out_lane",  32'(out_lane),  32'(m_lane));
      chk("active",    32'(active),    32'(e_act));
      chk("fifo_full", 32'(fifo_full), 32'(e_full));
      chk("overflow",  32'(overflow),  32'(e_ovf));
   endtask

   task automatic tick();
      @(posedge clk4f);
      if (!reset) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   task automatic cyc(input logic [3:0] v, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input logic rdy);
      valid_in  = v;
      in0       = b0;
      in1       = b1;
      in2       = b2;
      in3       = b3;
      out_ready = rdy;
      tick();
   endtask

   initial begin
      model_reset();
      repeat (2) cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_active",    32'(active),    32'd0);
      reset = 1'b1;

      // Alignment on lane 0 with an interrupting non-comma byte
      for (int i = 0; i < 8; i++) begin
         cyc(4'b0001, align_seq[i], 8'h00, 8'h00, 8'h00, 1'b1);
         if (i == 6) chk("align_early", 32'(active[0]), 32'd0);
      end
      chk("align_done",   32'(active),    32'h1);
      chk("align_no_out", 32'(out_valid), 32'd0);
      repeat (4) cyc(4'hE, 8'h00, COMMA, COMMA, COMMA, 1'b1);
      chk("all_active", 32'(active), 32'hF);

      // Simultaneous bytes on all lanes drain in lane order
      cyc(4'hF, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
         chk("rr_data", 32'(out_data), 32'(8'h10 * (k + 1)));
         chk("rr_lane", 32'(out_lane), 32'(k));
      end
      cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      chk("rr_idle", 32'(out_valid), 32'd0);

      // Held A7 under backpressure while lane 2 fills and overflows
      cyc(4'b0010, 8'h00, 8'hA7, 8'h00, 8'h00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc(4'b0100, 8'h00, 8'h00, 8'(8'h61 + k), 8'h00, 1'b0);
         chk("hold_data", 32'(out_data), 32'hA7);
         if (k == 3) begin
            chk("full2", 32'(fifo_full[2]), 32'd1);
            chk("no_ovf2_yet", 32'(overflow[2]), 32'd0);
         end
      end
      chk("ovf2", 32'(overflow[2]), 32'd1);
      for (int k = 0; k < 4; k++) begin
         cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
         chk("drain2_data", 32'(out_data), 32'(8'h61 + k));
         chk("drain2_lane", 32'(out_lane), 32'd2);
      end
      cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      chk("lost5", 32'(out_valid), 32'd0);

      // Lane 1 full and popped in the same cycle as a push
      for (int k = 0; k < 5; k++)
         cyc(4'b0010, 8'h00, 8'(8'h71 + k), 8'h00, 8'h00, 1'b0);
      chk("full1", 32'(fifo_full[1]), 32'd1);
      cyc(4'b0010, 8'h00, 8'h76, 8'h00, 8'h00, 1'b1);
      chk("pushpop_ovf1",  32'(overflow[1]),  32'd0);
      chk("pushpop_full1", 32'(fifo_full[1]), 32'd1);
      chk("pushpop_data",  32'(out_data),     32'h72);
      for (int k = 0; k < 4; k++) begin
         cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
         chk("drain1_data", 32'(out_data), 32'(8'h73 + k));
      end

      // Asynchronous reset between edges with a byte held
      cyc(4'b1000, 8'h00, 8'h00, 8'h00, 8'h88, 1'b0);
      cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid",    32'(out_valid), 32'd0);
      chk("arst_data",     32'(out_data),  32'd0);
      chk("arst_lane",     32'(out_lane),  32'd0);
      chk("arst_active",   32'(active),    32'd0);
      chk("arst_full",     32'(fifo_full), 32'd0);
      chk("arst_overflow", 32'(overflow),  32'd0);
      model_reset();
      cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      reset = 1'b1;
      repeat (2) cyc(4'hF, 8'h55, 8'h55, 8'h55, 8'h55, 1'b1);
      repeat (3) cyc(4'hF, COMMA, COMMA, COMMA, COMMA, 1'b1);
      chk("realign_pending", 32'(active), 32'd0);
      cyc(4'hF, COMMA, COMMA, COMMA, COMMA, 1'b1);
      chk("realign_done", 32'(active), 32'hF);

      // Random traffic: commas frequent, backpressure varies by phase
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] rb [4];
         logic rdy;
         for (int i = 0; i < 4; i++)
            rb[i] = ($urandom_range(0, 2) == 0) ? COMMA : 8'($urandom_range(0, 255));
         rdy = (n < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         if (n == 1500) begin
            reset = 1'b0;
            cyc(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
            reset = 1'b1;
         end
         cyc(4'($urandom), rb[0], rb[1], rb[2], rb[3], rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/phy_rx_lane_sched.md
PHY_RX_LANE_SCHED -- requirements
Module: phy_rx_lane_sched

Interface
REQ-001 Parameter DEPTH, default 4: entries per lane FIFO; power of two, at least 2.
REQ-002 Parameter COMMA, default 8'hBC: comma/idle symbol.
REQ-003 Parameter ALIGN_CNT, default 4: consecutive commas required to activate a lane.
REQ-004 Port clk4f, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Ports in0, in1, in2, in3, input, 8 bits each: lane bytes from the RX deserializers.
REQ-007 Port valid_in, input, 4 bits: bit i qualifies in<i> for one cycle.
REQ-008 Port out_data, output, 8 bits: scheduled byte.
REQ-009 Port out_lane, output, 2 bits: source lane of out_data.
REQ-010 Port out_valid, output, 1 bit: out_data/out_lane hold a valid byte.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the byte when out_valid and out_ready are both high at a clock edge.
REQ-012 Port active, output, 4 bits: lane i is aligned.
REQ-013 Port fifo_full, output, 4 bits: lane i FIFO holds DEPTH entries.
REQ-014 Port overflow, output, 4 bits: sticky; lane i dropped a byte.

Function
REQ-015 Each lane SHALL run a two-state FSM: INACTIVE and ACTIVE.
REQ-016 INACTIVE: a valid COMMA byte increments the lane comma counter; a valid non-COMMA byte clears it; cycles without valid leave it unchanged.
REQ-017 INACTIVE -> ACTIVE at the edge the counter reaches ALIGN_CNT; active[i] is high from that edge.
REQ-018 ACTIVE persists until reset; there is no other exit.
REQ-019 All bytes received while INACTIVE, including the activating comma, are discarded.
REQ-020 ACTIVE: valid COMMA bytes are discarded as idle; valid non-COMMA bytes are pushed into the lane FIFO.
REQ-021 Each lane FIFO is DEPTH deep with an occupancy count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-022 A push to a full FIFO is accepted only if the same lane is popped in the same cycle; otherwise the byte is dropped, overflow[i] is set and stays set until reset, and FIFO contents are unchanged.
REQ-023 The output stage is a single register; it loads when out_valid==0 or (out_valid && out_ready).
REQ-024 On load, a round-robin arbiter picks the first non-empty lane after last_grant (modulo 4), pops one byte into out_data, sets out_lane, and updates last_grant.
REQ-025 If the output stage loads and no lane is non-empty, out_valid goes low; out_data and out_lane hold their previous values.
REQ-026 While out_valid && !out_ready, out_data, out_lane and out_valid SHALL remain stable and no FIFO is popped.
REQ-027 Latency: a byte pushed into an empty FIFO at edge N, with no competing lane and the output stage free, appears with out_valid high after edge N+1.
REQ-028 Only occupancy before the edge counts toward arbitration; a byte pushed at edge N is not eligible until edge N+1.
REQ-029 fifo_full[i] is registered and equals (count_i == DEPTH).
REQ-030 Valid bytes on all four lanes in the same cycle are each processed independently.

Reset
REQ-031 While reset is low: every lane INACTIVE, comma counters 0, FIFOs empty, pointers 0.
REQ-032 While reset is low: out_data=0, out_lane=0, out_valid=0, active=0, fifo_full=0, overflow=0, last_grant=3, so lane 0 has first priority.
REQ-033 Assertion of reset mid-operation clears all state immediately, including any held output byte, which is lost.
REQ-034 After reset deasserts, operation starts at the first rising clk4f edge.

Verification
REQ-035 Lane 0 receives BC, BC, BC, 55, BC×4 -> active[0] rises only after the 8th byte; 55 and all commas never appear on the output.
REQ-036 All lanes active; in0..in3 = 10, 20, 30, 40 in one cycle; out_ready=1 -> outputs 10, 20, 30, 40 on consecutive cycles with out_lane 0, 1, 2, 3.
REQ-037 Lane 2 active; out_ready=0; push 5 distinct bytes -> fifo_full[2]=1 after the 4th push and overflow[2]=1; release out_ready -> first 4 bytes delivered in order, 5th byte lost.
REQ-038 out_valid=1 with byte A7 and out_ready=0 for 3 cycles -> out_data stays A7 and no FIFO pops; out_ready=1 -> next byte is loaded at the following edge.
REQ-039 Lane 1 full and being popped while a push arrives in the same cycle -> byte accepted, overflow[1] stays 0, count unchanged.
REQ-040 Reset asserted between clock edges while out_valid=1 -> all outputs go to 0 immediately without waiting for a clock edge, and lanes must realign after reset.
